// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone command initiator and related agents:
// FSM state encoding, default bus widths and command/response records.
// No ports (package).
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_e;

   typedef struct packed {
      logic                 we;
      logic [WB_AW-1:0]     adr;
      logic [WB_DW-1:0]     dat;
      logic [WB_DW/8-1:0]   sel;
   } wb_cmd_t;

   typedef struct packed {
      logic [WB_DW-1:0]     dat;
      logic                 err;
   } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// ----------------------------------------------------------------------------
// wb_timeout_ctr
// Saturating wait-cycle counter for bus agents. Flags expiry when the count
// reaches TIMEOUT-1, i.e. on the TIMEOUT-th enabled cycle after a clear.
// TIMEOUT = 0 disables expiry entirely.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clr_i      synchronous clear (dominates enable)
//   en_i       count one cycle
//   expired_o  current cycle is the last permitted wait cycle
// ----------------------------------------------------------------------------
module wb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
   localparam logic          USED = (TIMEOUT > 0) ? 1'b1 : 1'b0;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise saturating increment while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CW{1'b0}};
      end else if (en_i && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + CW'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = USED && (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// ----------------------------------------------------------------------------
// wb_cmd_initiator
// Wishbone classic single-transfer initiator. Each accepted command runs one
// CYC/STB cycle; the result (read data or timeout error) is returned on the
// response port. One transfer outstanding at a time.
// Ports:
//   wb_clk_i / wb_rst_ni         clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i/adr_i/dat_i/sel_i   command fields
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o / rsp_err_o        read data (0 for writes/errors), timeout flag
//   wbm_*                        Wishbone initiator signals
// ----------------------------------------------------------------------------
module wb_cmd_initiator
   import wb_pkg::*;
#(
   parameter int AW      = WB_AW,
   parameter int DW      = WB_DW,
   parameter int TIMEOUT = 255
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_ni,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic            cmd_we_i,
   input  logic [AW-1:0]   cmd_adr_i,
   input  logic [DW-1:0]   cmd_dat_i,
   input  logic [DW/8-1:0] cmd_sel_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_dat_o,
   output logic            rsp_err_o,
   output logic            wbm_cyc_o,
   output logic            wbm_stb_o,
   output logic            wbm_we_o,
   output logic [DW/8-1:0] wbm_sel_o,
   output logic [AW-1:0]   wbm_adr_o,
   output logic [DW-1:0]   wbm_dat_o,
   input  logic [DW-1:0]   wbm_dat_i,
   input  logic            wbm_ack_i
);

   wb_state_e       state_q;
   logic            cyc_q;
   logic            we_q;
   logic [DW/8-1:0] sel_q;
   logic [AW-1:0]   adr_q;
   logic [DW-1:0]   dat_q;
   logic            rsp_valid_q;
   logic [DW-1:0]   rsp_dat_q;
   logic            rsp_err_q;
   logic            tmo_expired_s;

   // Counter restarts whenever we are not waiting on the bus, so it is zero
   // on the first STB cycle of every transfer.
   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_i     (wb_clk_i),
      .rst_ni    (wb_rst_ni),
      .clr_i     (state_q != BUS),
      .en_i      (state_q == BUS),
      .expired_o (tmo_expired_s)
   );

   // Transfer FSM with all bus and response outputs registered.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= {(DW/8){1'b0}};
         adr_q       <= {AW{1'b0}};
         dat_q       <= {DW{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= {DW{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  we_q    <= cmd_we_i;
                  sel_q   <= cmd_sel_i;
                  adr_q   <= cmd_adr_i;
                  dat_q   <= cmd_dat_i;
                  cyc_q   <= 1'b1;
                  state_q <= BUS;
               end
            end
            BUS: begin
               // ACK takes priority over a timeout expiring on the same edge.
               if (wbm_ack_i) begin
                  cyc_q       <= 1'b0;
                  rsp_dat_q   <= we_q ? {DW{1'b0}} : wbm_dat_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else if (tmo_expired_s) begin
                  cyc_q       <= 1'b0;
                  rsp_dat_q   <= {DW{1'b0}};
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               cyc_q       <= 1'b0;
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = (state_q == IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_dat_o   = rsp_dat_q;
   assign rsp_err_o   = rsp_err_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_we_o    = we_q;
   assign wbm_sel_o   = sel_q;
   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// ----------------------------------------------------------------------------
// tb_wb_cmd_initiator
// Directed bench for wb_cmd_initiator with TIMEOUT = 8. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_wb_cmd_initiator;
   import wb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_we;
   logic [AW-1:0]   cmd_adr;
   logic [DW-1:0]   cmd_dat;
   logic [DW/8-1:0] cmd_sel;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_dat;
   logic            rsp_err;
   logic            cyc;
   logic            stb;
   logic            we;
   logic [DW/8-1:0] sel;
   logic [AW-1:0]   adr;
   logic [DW-1:0]   wdat;
   logic [DW-1:0]   rdat;
   logic            ack;

   int n_vec = 0;
   int n_err = 0;

   wb_cmd_initiator #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (8)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .cmd_sel_i   (cmd_sel),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (cyc),
      .wbm_stb_o   (stb),
      .wbm_we_o    (we),
      .wbm_sel_o   (sel),
      .wbm_adr_o   (adr),
      .wbm_dat_o   (wdat),
      .wbm_dat_i   (rdat),
      .wbm_ack_i   (ack)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute run-time bound.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command, let it be accepted, then play the slave: ACK on the
   // ack_on-th STB cycle (0 = never). Returns the number of CYC cycles seen.
   task automatic do_xfer(input wb_cmd_t c, input int ack_on,
                          input logic [DW-1:0] slave_dat, output int cyc_cnt);
      int guard;
      cmd_valid = 1'b1;
      cmd_we    = c.we;
      cmd_adr   = c.adr;
      cmd_dat   = c.dat;
      cmd_sel   = c.sel;
      check_eq("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      cmd_adr   = 32'h0;
      cmd_dat   = 32'h0;
      cyc_cnt   = 0;
      guard     = 0;
      while (cyc && guard < 40) begin
         cyc_cnt++;
         guard++;
         check_eq("stb_eq_cyc", 64'(stb), 64'd1);
         check_eq("adr_hold", 64'(adr), 64'(c.adr));
         check_eq("we_hold", 64'(we), 64'(c.we));
         check_eq("sel_hold", 64'(sel), 64'(c.sel));
         check_eq("wdat_hold", 64'(wdat), 64'(c.dat));
         check_eq("cmd_ready_bus", 64'(cmd_ready), 64'd0);
         ack  = (cyc_cnt == ack_on);
         rdat = (cyc_cnt == ack_on) ? slave_dat : 32'hBAD0_BAD0;
         tick();
      end
      ack  = 1'b0;
      rdat = 32'hBAD0_BAD0;
      if (guard >= 40) check_eq("cyc_bounded", 64'(guard), 64'd0);
   endtask

   task automatic take_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_eq("rsp_valid_clr", 64'(rsp_valid), 64'd0);
      check_eq("cmd_ready_back", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      wb_cmd_t c;
      int      n;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0;
      cmd_dat = 32'h0; cmd_sel = 4'h0; rsp_ready = 1'b0;
      rdat = 32'hBAD0_BAD0; ack = 1'b0;
      tick(); tick();

      // Reset state
      check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check_eq("rst_cyc", 64'(cyc), 64'd0);
      check_eq("rst_stb", 64'(stb), 64'd0);
      check_eq("rst_adr", 64'(adr), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_rsp_dat", 64'(rsp_dat), 64'd0);
      check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
      #3 rst_n = 1'b1;
      tick();

      // Write, zero-wait slave
      c = '{we: 1'b1, adr: 32'h3000_0004, dat: 32'hDEAD_BEEF, sel: 4'hF};
      do_xfer(c, 1, 32'h1111_2222, n);
      check_eq("wr_cyc_len", 64'(n), 64'd1);
      check_eq("wr_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("wr_rsp_err", 64'(rsp_err), 64'd0);
      check_eq("wr_rsp_dat", 64'(rsp_dat), 64'd0);
      take_rsp();
      check_eq("wr_adr_retained", 64'(adr), 64'h3000_0004);

      // Read, 3 wait states
      c = '{we: 1'b0, adr: 32'h3000_0000, dat: 32'h0, sel: 4'hF};
      do_xfer(c, 4, 32'h1234_5678, n);
      check_eq("rd_cyc_len", 64'(n), 64'd4);
      check_eq("rd_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("rd_rsp_dat", 64'(rsp_dat), 64'h1234_5678);
      check_eq("rd_rsp_err", 64'(rsp_err), 64'd0);
      take_rsp();

      // Timeout: slave never answers
      c = '{we: 1'b0, adr: 32'h3000_0010, dat: 32'h0, sel: 4'h3};
      do_xfer(c, 0, 32'h0, n);
      check_eq("to_cyc_len", 64'(n), 64'd8);
      check_eq("to_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("to_rsp_err", 64'(rsp_err), 64'd1);
      check_eq("to_rsp_dat", 64'(rsp_dat), 64'd0);
      take_rsp();

      // ACK on the expiry cycle wins
      c = '{we: 1'b0, adr: 32'h3000_0014, dat: 32'h0, sel: 4'hF};
      do_xfer(c, 8, 32'h8765_4321, n);
      check_eq("ack8_cyc_len", 64'(n), 64'd8);
      check_eq("ack8_rsp_err", 64'(rsp_err), 64'd0);
      check_eq("ack8_rsp_dat", 64'(rsp_dat), 64'h8765_4321);
      take_rsp();

      // Response backpressure with a new command waiting
      c = '{we: 1'b0, adr: 32'h3000_0020, dat: 32'h0, sel: 4'hF};
      do_xfer(c, 1, 32'hAAAA_5555, n);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0008;
      cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h1;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         check_eq("bp_rsp_dat", 64'(rsp_dat), 64'hAAAA_5555);
         check_eq("bp_cmd_ready", 64'(cmd_ready), 64'd0);
         check_eq("bp_cyc", 64'(cyc), 64'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check_eq("bp_rsp_done", 64'(rsp_valid), 64'd0);
      check_eq("bp_not_yet_acc", 64'(cyc), 64'd0);
      check_eq("bp_ready_after", 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      check_eq("bp_acc_cyc", 64'(cyc), 64'd1);
      check_eq("bp_acc_adr", 64'(adr), 64'h3000_0008);
      check_eq("bp_acc_sel", 64'(sel), 64'h1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check_eq("bp_wr_rsp", 64'(rsp_valid), 64'd1);
      take_rsp();

      // Stray ACK in IDLE
      ack = 1'b1;
      tick();
      tick();
      ack = 1'b0;
      check_eq("stray_idle_cyc", 64'(cyc), 64'd0);
      check_eq("stray_idle_rsp", 64'(rsp_valid), 64'd0);
      check_eq("stray_idle_rdy", 64'(cmd_ready), 64'd1);

      // Stray ACK in RESP
      c = '{we: 1'b0, adr: 32'h3000_0030, dat: 32'h0, sel: 4'hF};
      do_xfer(c, 1, 32'h0F0F_0F0F, n);
      ack  = 1'b1;
      rdat = 32'hFFFF_0000;
      tick();
      tick();
      ack = 1'b0;
      check_eq("stray_resp_valid", 64'(rsp_valid), 64'd1);
      check_eq("stray_resp_dat", 64'(rsp_dat), 64'h0F0F_0F0F);
      check_eq("stray_resp_cyc", 64'(cyc), 64'd0);
      take_rsp();
      tick();
      check_eq("stray_no_extra", 64'(rsp_valid), 64'd0);

      // Asynchronous reset while waiting on the bus
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
      tick();
      cmd_valid = 1'b0;
      tick();
      check_eq("arst_pre_cyc", 64'(cyc), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_cyc", 64'(cyc), 64'd0);
      check_eq("arst_stb", 64'(stb), 64'd0);
      check_eq("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      check_eq("arst_idle_rdy", 64'(cmd_ready), 64'd1);
      check_eq("arst_idle_cyc", 64'(cyc), 64'd0);
      c = '{we: 1'b0, adr: 32'h3000_0044, dat: 32'h0, sel: 4'hF};
      do_xfer(c, 2, 32'hCAFE_F00D, n);
      check_eq("arst_rd_len", 64'(n), 64'd2);
      check_eq("arst_rd_dat", 64'(rsp_dat), 64'hCAFE_F00D);
      check_eq("arst_rd_err", 64'(rsp_err), 64'd0);
      take_rsp();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic single-transfer initiator: the initiator end of the bus that the user project implements as a Wishbone slave.
- Accepts read/write commands on a valid/ready command port and runs one Wishbone cycle per command.
- Returns read data or a timeout error on a valid/ready response port.
- Used for bench-side exercising of the user project slave and for on-chip bridging (e.g. logic-analyzer-driven bus access).

Parameters:
- AW, 32, address width
- DW, 32, data width (SEL width = DW/8)
- TIMEOUT, 255, cycles of STB without ACK before abort; 0 disables timeout

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  AW  address
- cmd_dat_i  in  DW  write data
- cmd_sel_i  in  DW/8  byte selects
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  DW  read data (0 for writes and errors)
- rsp_err_o  out  1  1=timeout
- wbm_cyc_o  out  1  Wishbone CYC
- wbm_stb_o  out  1  Wishbone STB
- wbm_we_o  out  1  Wishbone WE
- wbm_sel_o  out  DW/8  Wishbone SEL
- wbm_adr_o  out  AW  Wishbone ADR
- wbm_dat_o  out  DW  Wishbone write data
- wbm_dat_i  in  DW  Wishbone read data
- wbm_ack_i  in  1  Wishbone ACK

Behaviour:
- All outputs are registered except cmd_ready_o, which is decoded from state.
- Reset (asynchronous, immediate): state IDLE; cyc/stb/we = 0; adr/dat/sel = 0; rsp_valid = 0; rsp_dat = 0; rsp_err = 0; timeout counter = 0.
- Reset mid-transfer drops CYC/STB immediately. The pending command and response are discarded.
- States:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i, latch we/adr/dat/sel onto the wbm_* outputs, set cyc = stb = 1, clear the counter, go to BUS. Accept at edge T gives CYC/STB high from T+1.
  - BUS: cmd_ready_o = 0; CYC, STB and all wbm_* signals are held stable.
    - ACK sampled high: clear cyc/stb; rsp_dat = read ? wbm_dat_i : 0; rsp_err = 0; rsp_valid = 1; go to RESP. Minimum command-to-response latency is 2 cycles (zero-wait slave).
    - No ACK and TIMEOUT != 0 and counter == TIMEOUT-1: clear cyc/stb; rsp_err = 1; rsp_dat = 0; rsp_valid = 1; go to RESP.
    - ACK on the same edge as timeout expiry: ACK wins, rsp_err = 0.
    - Otherwise increment the counter, saturating.
  - RESP: cmd_ready_o = 0; rsp_valid_o held with data/err stable until rsp_ready_i is sampled high. On that edge clear rsp_valid and go to IDLE. The next command can be accepted on the cycle after the handshake.
- wbm_ack_i sampled in IDLE or RESP (late or stray ACK) is ignored and causes no state change.
- Timeout counter width is $clog2(TIMEOUT+1), minimum 1. With TIMEOUT = 0 the counter is not used and BUS waits indefinitely.
- wbm_we/sel/adr/dat retain their last values after a cycle ends. Only CYC/STB are qualifiers.
- Only one outstanding transfer; no pipelining, bursts, ERR or RTY.

Decomposition:
- Shared package wb_pkg:
  - state enum {IDLE, BUS, RESP}
  - default AW/DW constants
  - command/response struct typedefs (we, adr, dat, sel; dat, err)
- Sub-module wb_timeout_ctr (clear, enable, expired output, TIMEOUT parameter) is natural and reusable by other bus agents.
- The FSM and registers live in the top module.

Test Plan:
- Write, zero-wait: cmd we=1 adr=0x3000_0004 dat=0xDEADBEEF sel=0xF; slave ACKs the first STB cycle -> one-cycle CYC/STB with those values; rsp_valid 2 cycles after accept, rsp_err=0, rsp_dat=0.
- Read, 3 wait states: cmd we=0 adr=0x3000_0000; slave ACKs on the 4th STB cycle with 0x1234_5678 -> CYC high exactly 4 cycles; rsp_dat=0x1234_5678, err=0.
- Timeout, TIMEOUT=8: slave never ACKs -> CYC high exactly 8 cycles, then rsp_err=1, rsp_dat=0. With ACK forced on the 8th cycle -> rsp_err=0.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/dat held stable, cmd_ready=0; a new cmd is accepted only the cycle after the rsp handshake.
- Stray ACK: pulse wbm_ack_i in IDLE and in RESP -> no state change, no extra response.
- Async reset in BUS: deassert wb_rst_ni mid-wait -> CYC/STB/rsp_valid low immediately; after release, IDLE with cmd_ready=1 and a fresh read completes normally.
